mgt_01_i_wb_arbiter: RTL and testbench

MGT_01_I_WB_ARBITER -- requirements
Module: MGT_01_i_wb_arbiter

---
 rtl/mgt_01_i_wb_arbiter_pkg.sv | 28 ++
 rtl/mgt_01_i_wb_arbiter_rr.sv | 83 ++++++++
 rtl/mgt_01_i_wb_arbiter.sv | 110 +++++++++++
 tb/tb_mgt_01_i_wb_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mgt_01_i_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mgt_01_pkg
// Shared types for the integer write-back path: register names, the data bus
// type and the default number of write-back requesters (ALU, LSU, MUL/DIV).
// -----------------------------------------------------------------------------
package mgt_01_pkg;

  localparam int unsigned N_REQ_DEFAULT = 3;
  localparam int unsigned XLEN          = 32;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  // One-hot mask of a register, with X0 mapped to an empty mask since it never
  // holds state.
  function automatic logic [31:0] reg_mask(input i_register_e rd);
    logic [31:0] m;
    m = 32'd1 << 5'(rd);
    return m & ~32'd1;
  endfunction

endpackage

// File: rtl/mgt_01_i_wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mgt_01_rr_arbiter
// Round-robin grant logic with its priority pointer. The search starts at the
// pointer and wraps modulo N_REQ; after a grant the pointer moves just past the
// winner, otherwise it holds.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   valid_i        : request vector
//   grant_o        : one-hot grant (combinational, forced low during reset)
//   idx_o          : index of the granted requester
//   gnt_any_o      : a grant is issued this cycle
// -----------------------------------------------------------------------------
module mgt_01_rr_arbiter #(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             gnt_any_o
);

  localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] p_q, p_d;
  logic [N_REQ-1:0] grant_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Priority search from the pointer upward with wrap-around.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum_s  = {1'b0, p_q} + (IDX_W+1)'(i);
      cand_s = (sum_s >= N_W) ? IDX_W'(sum_s - N_W) : IDX_W'(sum_s);
      if (!found_s && valid_i[cand_s]) begin
        found_s         = 1'b1;
        idx_s           = cand_s;
        grant_s[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer and reset-gated outputs; the gating keeps grants low while
  // reset is asserted even though the path is combinational.
  always_comb begin
    p_d = p_q;
    if (found_s) begin
      p_d = (idx_s == LAST) ? '0 : idx_s + IDX_W'(1);
    end else begin
      p_d = p_q;
    end
    if (rst_n_i) begin
      grant_o   = grant_s;
      gnt_any_o = found_s;
    end else begin
      grant_o   = '0;
      gnt_any_o = 1'b0;
    end
    idx_o = idx_s;
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/mgt_01_i_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mgt_01_i_wb_arbiter
// Integer write-back arbiter: picks one of N_REQ result producers per cycle
// (round-robin), registers its destination/data toward the register file and
// tracks which registers still have a write outstanding.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   req_valid_i/rd/data   : per-requester write-back request
//   req_ready_o           : per-requester grant (combinational)
//   issue_valid_i/rd_i    : instruction issue with a destination register
//   we_o/w_iaddr_o/wr_idata_o : register-file write port, one cycle after grant
//   pending_o             : bit n set while Xn has an outstanding write
// -----------------------------------------------------------------------------
module mgt_01_i_wb_arbiter
  import mgt_01_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEFAULT,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  i_register_e      req_rd_i   [N_REQ],
  input  data_bus_t        req_data_i [N_REQ],
  output logic [N_REQ-1:0] req_ready_o,
  input  logic             issue_valid_i,
  input  i_register_e      issue_rd_i,
  output logic             we_o,
  output i_register_e      w_iaddr_o,
  output data_bus_t        wr_idata_o,
  output logic [31:0]      pending_o
);

  logic [N_REQ-1:0] grant_s;
  logic [IDX_W-1:0] idx_s;
  logic             gnt_any_s;
  logic [4:0]       sel_rd_s;
  data_bus_t        sel_data_s;
  logic [31:0]      set_mask_s, clr_mask_s;

  logic        we_q, we_d;
  i_register_e waddr_q, waddr_d;
  data_bus_t   wdata_q, wdata_d;
  logic [31:0] pending_q, pending_d;

  mgt_01_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (req_valid_i),
    .grant_o   (grant_s),
    .idx_o     (idx_s),
    .gnt_any_o (gnt_any_s)
  );

  assign req_ready_o = grant_s;

  // One-hot AND-OR mux of the granted requester's rd and data.
  always_comb begin
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sel_rd_s   = sel_rd_s   | (grant_s[k] ? 5'(req_rd_i[k]) : 5'd0);
      sel_data_s = sel_data_s | (grant_s[k] ? req_data_i[k]   : '0);
    end
  end

  // Next write-port state: X0 results are accepted but never written; with no
  // grant the address and data hold so the port does not toggle needlessly.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_any_s) begin
      we_d    = (sel_rd_s != 5'd0);
      waddr_d = i_register_e'(sel_rd_s);
      wdata_d = sel_data_s;
    end else begin
      we_d = 1'b0;
    end
  end

  // Pending scoreboard: clear on handshake, set on issue; set is applied last
  // so it wins when both hit one register. X0 is masked off by reg_mask.
  always_comb begin
    clr_mask_s = gnt_any_s ? reg_mask(i_register_e'(sel_rd_s)) : 32'd0;
    set_mask_s = issue_valid_i ? reg_mask(issue_rd_i) : 32'd0;
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
  end

  // Output and scoreboard registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q      <= 1'b0;
      waddr_q   <= X0;
      wdata_q   <= '0;
      pending_q <= 32'd0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign we_o       = we_q;
  assign w_iaddr_o  = waddr_q;
  assign wr_idata_o = wdata_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_mgt_01_i_wb_arbiter.sv
module tb_mgt_01_i_wb_arbiter;
  import mgt_01_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  i_register_e req_rd   [N];
  data_bus_t   req_data [N];
  logic [N-1:0] req_ready;
  logic        issue_valid = 1'b0;
  i_register_e issue_rd = X0;
  logic        we;
  i_register_e w_iaddr;
  data_bus_t   wr_idata;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  mgt_01_i_wb_arbiter #(.N_REQ(N)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid),
    .req_rd_i      (req_rd),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .we_o          (we),
    .w_iaddr_o     (w_iaddr),
    .wr_idata_o    (wr_idata),
    .pending_o     (pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] v,
                         input i_register_e r0, input data_bus_t d0,
                         input i_register_e r1, input data_bus_t d1,
                         input i_register_e r2, input data_bus_t d2);
    req_valid   = v;
    req_rd[0]   = r0; req_data[0] = d0;
    req_rd[1]   = r1; req_data[1] = d1;
    req_rd[2]   = r2; req_data[2] = d2;
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%0h required no write",
                 w_iaddr, wr_idata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, 5'(w_iaddr)}, {27'd0, e.addr});
        chk("wr_data", wr_idata, e.data);
      end
    end
  end

  initial begin
    logic [N-1:0] order [6];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100;
    order[3] = 3'b001; order[4] = 3'b010; order[5] = 3'b100;

    // Reset state with requests and an issue present: ready must be forced low.
    set_req(3'b111, X1, 32'd10, X2, 32'd20, X3, 32'd30);
    issue_valid = 1'b1; issue_rd = X7;
    #1;
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", {27'd0, 5'(w_iaddr)}, 32'd0);
    chk("rst_data", wr_idata, 32'd0);
    @(posedge clk); #1;
    chk("rst_pending", pending, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0; issue_valid = 1'b0;
    next_cycle();

    // All three valid from p=0: grants 0,1,2,0,1,2.
    set_req(3'b111, X1, 32'd10, X2, 32'd20, X3, 32'd30);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_%0d", c), {29'd0, req_ready}, {29'd0, order[c]});
      exp_q.push_back(wr_t'{addr: 5'(c % 3 + 1), data: 32'(10 * (c % 3 + 1))});
      next_cycle();
    end

    // Only LSU valid, X5 / 1000 (p=0 -> grant 1, p becomes 2).
    set_req(3'b010, X0, 32'd0, X5, 32'd1000, X0, 32'd0);
    @(negedge clk);
    chk("lsu_ready", {29'd0, req_ready}, 32'd2);
    exp_q.push_back(wr_t'{addr: 5'd5, data: 32'd1000});
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("lsu_we", {31'd0, we}, 32'd1);
    next_cycle();

    // ALU to X0: accepted, but no write (p=2 wraps to 0, then p=1).
    set_req(3'b001, X0, 32'd500, X0, 32'd0, X0, 32'd0);
    @(negedge clk);
    chk("x0_ready", {29'd0, req_ready}, 32'd1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("x0_we", {31'd0, we}, 32'd0);
    next_cycle();

    // Issue X7, MUL/DIV writes X7 three cycles later.
    issue_valid = 1'b1; issue_rd = X7;
    @(negedge clk);
    chk("x7_pend_before", {31'd0, pending[7]}, 32'd0);
    next_cycle();
    issue_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) set_req(3'b100, X0, 32'd0, X0, 32'd0, X7, 32'hCAFE_0007);
      @(negedge clk);
      chk($sformatf("x7_pend_%0d", c), {31'd0, pending[7]}, 32'd1);
      if (c == 3) begin
        chk("x7_ready", {29'd0, req_ready}, 32'd4);
        exp_q.push_back(wr_t'{addr: 5'd7, data: 32'hCAFE_0007});
      end
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    chk("x7_pend_after", pending, 32'd0);
    next_cycle();

    // Issue X3 in the same cycle as a granted write to X3: set wins (p=0 -> 1).
    set_req(3'b010, X0, 32'd0, X3, 32'd333, X0, 32'd0);
    issue_valid = 1'b1; issue_rd = X3;
    @(negedge clk);
    chk("x3_ready", {29'd0, req_ready}, 32'd2);
    exp_q.push_back(wr_t'{addr: 5'd3, data: 32'd333});
    next_cycle();
    req_valid = '0;
    issue_rd = X0;
    @(negedge clk);
    chk("x3_pend", pending, 32'h0000_0008);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("x0_issue_pend", pending, 32'h0000_0008);
    next_cycle();

    // Grant to X9, then reset pulsed before its write cycle completes (p=2 -> grant 0).
    set_req(3'b001, X9, 32'd77, X0, 32'd0, X0, 32'd0);
    @(negedge clk);
    chk("mid_ready", {29'd0, req_ready}, 32'd1);
    next_cycle();
    chk("mid_we_pre", {31'd0, we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_rst", {31'd0, we}, 32'd0);
    chk("mid_pend_rst", pending, 32'd0);
    chk("mid_ready_rst", {29'd0, req_ready}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    // Restart from p=0: all valid grants requester 0.
    set_req(3'b111, X4, 32'd1, X5, 32'd2, X6, 32'd3);
    @(negedge clk);
    chk("restart_ready", {29'd0, req_ready}, 32'd1);
    exp_q.push_back(wr_t'{addr: 5'd4, data: 32'd1});
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
